// File: rtl/selector_dw_pipe.sv
// ----------------------------------------------------------------------------
// selector_dw_pipe
//
// Registered write-back data selector. Picks one of NSRC WIDTH-bit sources by
// i_sel, pairs it with the destination register address and hands the pair to
// the register file through a two-entry valid/ready skid buffer. This lets the
// write port stall without losing data. An out-of-range select produces an
// all-zero word and raises a sticky error flag.
//
// Optional feature macro: SELECTOR_ERR_CNT_EN
//   defined   -> o_err_cnt is an 8-bit saturating count of out-of-range
//                accepts, cleared by i_clr_err.
//   undefined -> o_err_cnt is tied to zero.
//
// Ports
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_valid    : upstream offers a select/destination pair
//   o_ready    : buffer can accept this cycle (depends on state only)
//   i_sel      : source index, legal 0..NSRC-1
//   i_src      : flattened sources, source k = i_src[k*WIDTH +: WIDTH]
//   i_dst      : destination register address, passed through unchanged
//   o_valid    : o_dw/o_dst hold a write
//   i_ready    : register file consumes the write
//   o_dw       : selected write data
//   o_dst      : destination address paired with o_dw
//   o_sel_err  : sticky flag, an out-of-range select was accepted
//   i_clr_err  : synchronous clear of o_sel_err and o_err_cnt
//   o_err_cnt  : out-of-range select count (zero without the macro)
// ----------------------------------------------------------------------------
module selector_dw_pipe #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 5,
    parameter int SEL_W = 3,
    parameter int DST_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [NSRC*WIDTH-1:0] i_src,
    input  logic [DST_W-1:0]      i_dst,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WIDTH-1:0]      o_dw,
    output logic [DST_W-1:0]      o_dst,
    output logic                  o_sel_err,
    input  logic                  i_clr_err,
    output logic [7:0]            o_err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Full-width comparison: the select is never wrapped or truncated, so an
    // index past the last source yields zero rather than aliasing.
    function automatic logic [WIDTH-1:0] select_word(
        input logic [SEL_W-1:0]      sel,
        input logic [NSRC*WIDTH-1:0] src
    );
        logic [WIDTH-1:0] word;
        word = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (int'(sel) == k) begin
                word = src[k*WIDTH +: WIDTH];
            end
        end
        return word;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_dw_q, main_dw_d;
    logic [DST_W-1:0] main_dst_q, main_dst_d;
    logic [WIDTH-1:0] skid_dw_q, skid_dw_d;
    logic [DST_W-1:0] skid_dst_q, skid_dst_d;
    logic             sel_err_q, sel_err_d;

    logic             accept;
    logic             consume;
    logic             sel_oob;
    logic             bad_accept;
    logic [WIDTH-1:0] new_dw;

    assign o_valid    = (state_q != EMPTY);
    assign o_ready    = (state_q != FULL);
    assign accept     = i_valid & o_ready;
    assign consume    = o_valid & i_ready;
    assign sel_oob    = (int'(i_sel) >= NSRC);
    assign bad_accept = accept & sel_oob;
    assign new_dw     = select_word(i_sel, i_src);

    assign o_dw      = main_dw_q;
    assign o_dst     = main_dst_q;
    assign o_sel_err = sel_err_q;

    always_comb begin
        state_d    = state_q;
        main_dw_d  = main_dw_q;
        main_dst_d = main_dst_q;
        skid_dw_d  = skid_dw_q;
        skid_dst_d = skid_dst_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_dw_d  = new_dw;
                    main_dst_d = i_dst;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_dw_d  = new_dw;
                    main_dst_d = i_dst;
                end else if (accept) begin
                    // Output is stalled: park the new entry behind it.
                    skid_dw_d  = new_dw;
                    skid_dst_d = i_dst;
                    state_d    = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    main_dw_d  = skid_dw_q;
                    main_dst_d = skid_dst_q;
                    state_d    = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Clear first so that a same-cycle error wins.
    always_comb begin
        sel_err_d = sel_err_q;
        if (i_clr_err) begin
            sel_err_d = 1'b0;
        end
        if (bad_accept) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= EMPTY;
            main_dw_q  <= '0;
            main_dst_q <= '0;
            skid_dw_q  <= '0;
            skid_dst_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_dw_q  <= main_dw_d;
            main_dst_q <= main_dst_d;
            skid_dw_q  <= skid_dw_d;
            skid_dst_q <= skid_dst_d;
            sel_err_q  <= sel_err_d;
        end
    end

`ifdef SELECTOR_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] err_cnt_base;

    // A clear and a new error together restart the count at one.
    always_comb begin
        err_cnt_base = i_clr_err ? 8'd0 : err_cnt_q;
        err_cnt_d    = err_cnt_base;
        if (bad_accept && (err_cnt_base != 8'hFF)) begin
            err_cnt_d = err_cnt_base + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_selector_dw_pipe.sv
// ----------------------------------------------------------------------------
// Directed testbench for selector_dw_pipe (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a period after the rising edge that updated them.
// ----------------------------------------------------------------------------
module tb_selector_dw_pipe;

    localparam int WIDTH = 8;
    localparam int NSRC  = 5;
    localparam int SEL_W = 3;
    localparam int DST_W = 4;

`ifdef SELECTOR_ERR_CNT_EN
    localparam logic [7:0] CNT_SAT   = 8'd255;
    localparam logic [7:0] CNT_AFTER = 8'd1;
`else
    localparam logic [7:0] CNT_SAT   = 8'd0;
    localparam logic [7:0] CNT_AFTER = 8'd0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  valid_in;
    logic                  ready_out;
    logic [SEL_W-1:0]      sel;
    logic [NSRC*WIDTH-1:0] src;
    logic [DST_W-1:0]      dst;
    logic                  valid_out;
    logic                  ready_in;
    logic [WIDTH-1:0]      dw;
    logic [DST_W-1:0]      dst_out;
    logic                  sel_err;
    logic                  clr_err;
    logic [7:0]            err_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    selector_dw_pipe #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .DST_W(DST_W)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid_in),
        .o_ready  (ready_out),
        .i_sel    (sel),
        .i_src    (src),
        .i_dst    (dst),
        .o_valid  (valid_out),
        .i_ready  (ready_in),
        .o_dw     (dw),
        .o_dst    (dst_out),
        .o_sel_err(sel_err),
        .i_clr_err(clr_err),
        .o_err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected source word for sel k: sources are 0x11, 0x22, ... 0x55.
    function automatic logic [7:0] exp_word(input int k);
        return (k < NSRC) ? 8'(8'h11 * (k + 1)) : 8'h00;
    endfunction

    task automatic offer(input logic [SEL_W-1:0] s, input logic [DST_W-1:0] d);
        valid_in = 1'b1;
        sel      = s;
        dst      = d;
    endtask

    task automatic single_write(input string tag);
        @(negedge clk);
        ready_in = 1'b1;
        offer(3'd2, 4'd7);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq({tag, "_valid"}, 32'(valid_out), 32'd1);
        check_eq({tag, "_dw"},    32'(dw),        32'h33);
        check_eq({tag, "_dst"},   32'(dst_out),   32'd7);
        @(negedge clk);
        check_eq({tag, "_drain"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        sel      = '0;
        dst      = '0;
        clr_err  = 1'b0;
        src      = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_ready", 32'(ready_out), 32'd1);
        check_eq("rst_dw",    32'(dw),        32'd0);
        check_eq("rst_dst",   32'(dst_out),   32'd0);
        check_eq("rst_err",   32'(sel_err),   32'd0);
        check_eq("rst_cnt",   32'(err_cnt),   32'd0);
        rst_n = 1'b1;

        // Single write
        single_write("single");

        // Stall and skid
        ready_in = 1'b0;
        offer(3'd0, 4'd1);
        @(negedge clk);
        check_eq("skid_ready1", 32'(ready_out), 32'd1);
        offer(3'd1, 4'd2);
        @(negedge clk);
        check_eq("skid_full_ready", 32'(ready_out), 32'd0);
        check_eq("skid_head_dw",    32'(dw),        32'h11);
        offer(3'd4, 4'd3);
        @(negedge clk);
        check_eq("skid_hold_dw",    32'(dw),        32'h11);
        check_eq("skid_hold_dst",   32'(dst_out),   32'd1);
        check_eq("skid_hold_ready", 32'(ready_out), 32'd0);
        ready_in = 1'b1;
        @(negedge clk);
        check_eq("skid_drain1_dw",  32'(dw),        32'h22);
        check_eq("skid_drain1_dst", 32'(dst_out),   32'd2);
        check_eq("skid_ready_back", 32'(ready_out), 32'd1);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("skid_sel4_dw",  32'(dw),      32'h55);
        check_eq("skid_sel4_dst", 32'(dst_out), 32'd3);
        check_eq("skid_no_err",   32'(sel_err), 32'd0);
        @(negedge clk);
        check_eq("skid_empty", 32'(valid_out), 32'd0);

        // Full-rate stream
        for (int i = 0; i < 10; i++) begin
            offer(SEL_W'(i % NSRC), DST_W'(i));
            @(negedge clk);
            check_eq($sformatf("stream%0d_dw", i),    32'(dw),        32'(exp_word(i % NSRC)));
            check_eq($sformatf("stream%0d_dst", i),   32'(dst_out),   32'(i));
            check_eq($sformatf("stream%0d_ready", i), 32'(ready_out), 32'd1);
            check_eq($sformatf("stream%0d_valid", i), 32'(valid_out), 32'd1);
        end
        valid_in = 1'b0;
        @(negedge clk);
        check_eq("stream_empty", 32'(valid_out), 32'd0);

        // Out-of-range select, boundary sel == NSRC
        offer(3'd5, 4'd9);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("oob5_dw",  32'(dw),      32'd0);
        check_eq("oob5_dst", 32'(dst_out), 32'd9);
        check_eq("oob5_err", 32'(sel_err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("clr_err",     32'(sel_err), 32'd0);
        check_eq("clr_cnt",     32'(err_cnt), 32'd0);
        offer(3'd6, 4'd5);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("oob6_dw",  32'(dw),      32'd0);
        check_eq("oob6_dst", 32'(dst_out), 32'd5);
        check_eq("oob6_err", 32'(sel_err), 32'd1);
        @(negedge clk);

        // Counter saturation (300 bad accepts)
        for (int i = 0; i < 300; i++) begin
            offer(3'd7, 4'd0);
            @(negedge clk);
        end
        valid_in = 1'b0;
        @(negedge clk);
        check_eq("cnt_sat", 32'(err_cnt), 32'(CNT_SAT));
        // Clear together with a bad accept: set wins, count restarts at one
        clr_err = 1'b1;
        offer(3'd6, 4'd2);
        @(negedge clk);
        clr_err  = 1'b0;
        valid_in = 1'b0;
        check_eq("clr_set_err", 32'(sel_err), 32'd1);
        check_eq("clr_set_cnt", 32'(err_cnt), 32'(CNT_AFTER));
        @(negedge clk);

        // Reset mid-operation from FULL
        ready_in = 1'b0;
        offer(3'd0, 4'd1);
        @(negedge clk);
        offer(3'd1, 4'd2);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("pre_rst_full", 32'(ready_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(valid_out), 32'd0);
        check_eq("async_rst_ready", 32'(ready_out), 32'd1);
        check_eq("async_rst_dw",    32'(dw),        32'd0);
        check_eq("async_rst_dst",   32'(dst_out),   32'd0);
        check_eq("async_rst_err",   32'(sel_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        single_write("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
